// File: rtl/gsim_param.sv
// gsim_param: Gauss-Seidel solver for the banded system
//   20*x_i = b_i + 13(x_{i-1}+x_{i+1}) - 6(x_{i-2}+x_{i+2}) + (x_{i-3}+x_{i+3})
// It loads N signed integer b values, runs whole sweeps (one row per clock)
// until the sweep target or the tolerance is reached, then streams x out in
// signed Q.16 with a valid/ready handshake.
//
// Ports
//   clk        clock
//   reset      asynchronous active-high reset
//   in_en      b_in valid this cycle (ignored in CALC and OUT)
//   b_in       signed b element, b[0] first
//   iter_in    sweep target, sampled with b[0]; 0 selects MAX_ITER
//   tol_en     early-stop enable, sampled with b[0]
//   tol_in     unsigned Q.16 convergence threshold, sampled with b[0]
//   out_ready  downstream accepts x_out
//   out_valid  x_out holds a result element
//   x_out      signed Q.16 solution element, x[0] first
//   busy       high while loading, solving or streaming
//   iters_used completed sweeps (valid with out_valid)
//   converged  sweeps ended on tolerance (valid with out_valid)
module gsim_param #(
  parameter int N        = 16,
  parameter int B_W      = 16,
  parameter int X_W      = 32,
  parameter int MAX_ITER = 100
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [B_W-1:0] b_in,
  input  logic [15:0]    iter_in,
  input  logic           tol_en,
  input  logic [X_W-1:0] tol_in,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [X_W-1:0] x_out,
  output logic           busy,
  output logic [15:0]    iters_used,
  output logic           converged
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int SW = X_W + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  localparam logic signed [SW-1:0] K1  = SW'(1);
  localparam logic signed [SW-1:0] K6  = SW'(6);
  localparam logic signed [SW-1:0] K13 = SW'(13);
  localparam logic signed [SW-1:0] K20 = SW'(20);

  // Division by 20 rounding toward negative infinity, truncated to X_W bits.
  function automatic logic signed [X_W-1:0] div20_floor(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    logic signed [SW-1:0] r;
    q = s / K20;
    r = s - q * K20;
    if (r[SW-1]) q = q - K1;
    return q[X_W-1:0];
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic signed [X_W-1:0] v);
    return {{(SW - X_W){v[X_W-1]}}, v};
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic signed [B_W-1:0] b_q [N];
  logic signed [X_W-1:0] x_q [N];
  logic [15:0]           target_q, iters_q;
  logic                  tol_en_q;
  logic [X_W-1:0]        tol_q;
  logic [X_W:0]          md_q;
  logic                  out_valid_q, conv_q;
  logic [X_W-1:0]        x_out_q;

  logic signed [X_W-1:0] nb_lo [3];
  logic signed [X_W-1:0] nb_hi [3];
  logic signed [B_W-1:0] b_row;
  logic signed [SW-1:0]  b_ext, acc;
  logic signed [X_W-1:0] x_new, x_old;
  logic signed [X_W:0]   dlt;
  logic [X_W:0]          adl, md_now;
  logic                  last_row, hit_target, hit_tol, stop;

  // Row neighbours; out-of-range indices never match and so read as zero.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      nb_lo[k] = '0;
      nb_hi[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (int'(cnt_q) - k - 1 == i) nb_lo[k] = x_q[i];
        if (int'(cnt_q) + k + 1 == i) nb_hi[k] = x_q[i];
      end
    end
  end

  assign b_row = b_q[cnt_q[IW-1:0]];
  assign x_old = x_q[cnt_q[IW-1:0]];
  assign b_ext = $signed({{(SW - B_W){b_row[B_W-1]}}, b_row}) <<< 16;
  assign acc   = b_ext
               + K13 * (sx(nb_lo[0]) + sx(nb_hi[0]))
               - K6  * (sx(nb_lo[1]) + sx(nb_hi[1]))
               + sx(nb_lo[2]) + sx(nb_hi[2]);
  assign x_new = div20_floor(acc);

  assign dlt    = $signed({x_new[X_W-1], x_new}) - $signed({x_old[X_W-1], x_old});
  assign adl    = dlt[X_W] ? -dlt : dlt;
  assign md_now = (adl > md_q) ? adl : md_q;

  assign last_row   = (cnt_q == CNT_LAST);
  assign hit_target = ((iters_q + 16'd1) == target_q);
  assign hit_tol    = tol_en_q && (md_now <= {1'b0, tol_q});
  assign stop       = last_row && (hit_target || hit_tol);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_en) state_d = S_LOAD;
      // One settling cycle after the last b before the first row is solved.
      S_LOAD:  if (cnt_q == CNT_FULL) state_d = S_CALC;
      S_CALC:  if (stop) state_d = S_OUT;
      S_OUT:   if (out_valid_q && out_ready && last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      iters_q     <= '0;
      tol_en_q    <= 1'b0;
      tol_q       <= '0;
      md_q        <= '0;
      out_valid_q <= 1'b0;
      conv_q      <= 1'b0;
      x_out_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_en) begin
          cnt_q    <= CW'(1);
          target_q <= (iter_in == 16'd0) ? 16'(MAX_ITER) : iter_in;
          tol_en_q <= tol_en;
          tol_q    <= tol_in;
          iters_q  <= '0;
          conv_q   <= 1'b0;
          md_q     <= '0;
        end
        S_LOAD: begin
          if (cnt_q == CNT_FULL) cnt_q <= '0;
          else if (in_en)        cnt_q <= cnt_q + 1'b1;
        end
        S_CALC: begin
          if (last_row) begin
            iters_q <= iters_q + 16'd1;
            md_q    <= '0;
            cnt_q   <= '0;
            if (stop) conv_q <= hit_tol;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            md_q  <= md_now;
          end
        end
        S_OUT: begin
          // First OUT cycle primes x_out with x[0]; valid rises after it.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            x_out_q     <= x_q[0];
          end else if (out_ready) begin
            if (last_row) begin
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              x_out_q <= x_q[cnt_q[IW-1:0] + 1'b1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // b and x storage carry no reset; x is cleared when a new problem starts.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_en) begin
      b_q[0] <= b_in;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else if (state_q == S_LOAD && in_en && cnt_q != CNT_FULL) begin
      b_q[cnt_q[IW-1:0]] <= b_in;
    end else if (state_q == S_CALC) begin
      x_q[cnt_q[IW-1:0]] <= x_new;
    end
  end

  assign out_valid  = out_valid_q;
  assign x_out      = x_out_q;
  assign busy       = (state_q != S_IDLE);
  assign iters_used = iters_q;
  assign converged  = conv_q;

endmodule
